// File: rtl/frame_sync_ctrl.sv
// Frame-level handshake between VGA end-of-frame and the pong CPU: raises a pending flag per
// frame and commits the CPU ball position to display shadow registers when the CPU acknowledges.
module frame_sync_ctrl #(
  parameter logic [11:0] BASE_ADDR = 12'hF00,
  parameter int          CNT_W     = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        screenEnd,
  input  logic        wren,
  input  logic [11:0] address,
  input  logic [31:0] data,
  output logic [31:0] q,
  output logic        hit,
  input  logic [31:0] ball_x_cpu,
  input  logic [31:0] ball_y_cpu,
  input  logic [31:0] ball_xinit,
  input  logic [31:0] ball_yinit,
  output logic [31:0] ball_x,
  output logic [31:0] ball_y,
  output logic        frame_pending
);

  typedef enum logic [1:0] {IDLE, PENDING, COMMIT} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t           state;
  logic             se_d;
  logic             frame_edge;
  logic             ack;
  logic             carry_frame;
  logic             overrun_sticky;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] ovr_cnt;
  logic [11:0]      offset;
  logic             in_range;
  logic             unused_data;

  assign frame_edge    = screenEnd & ~se_d;
  assign offset        = address - BASE_ADDR;
  assign in_range      = (offset < 12'd4);
  assign ack           = wren && (offset == 12'd1);
  assign frame_pending = (state == PENDING);
  assign unused_data   = ^{data[31:2], data[0]};

  // Read port mirrors RAM timing: data for last cycle's address, zero outside the block.
  always_ff @(posedge clock) begin
    if (reset) begin
      q   <= 32'd0;
      hit <= 1'b0;
    end else begin
      hit <= in_range;
      q   <= 32'd0;
      if (in_range) begin
        case (offset[1:0])
          2'd0:    q <= {30'd0, overrun_sticky, frame_pending};
          2'd2:    q <= {{(32-CNT_W){1'b0}}, frame_cnt};
          2'd3:    q <= {{(32-CNT_W){1'b0}}, ovr_cnt};
          default: q <= 32'd0;
        endcase
      end
    end
  end

  // An ack that coincides with a new frame edge leaves carry_frame set so the
  // frame is re-announced right after the commit cycle instead of being lost.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      se_d           <= 1'b0;
      carry_frame    <= 1'b0;
      overrun_sticky <= 1'b0;
      frame_cnt      <= '0;
      ovr_cnt        <= '0;
      ball_x         <= ball_xinit;
      ball_y         <= ball_yinit;
    end else begin
      se_d <= screenEnd;
      if (ack && data[1]) overrun_sticky <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_edge) begin
            state     <= PENDING;
            frame_cnt <= frame_cnt + CNT_ONE;
          end
        end
        PENDING: begin
          if (ack) begin
            state       <= COMMIT;
            carry_frame <= frame_edge;
            if (frame_edge) frame_cnt <= frame_cnt + CNT_ONE;
          end else if (frame_edge) begin
            frame_cnt      <= frame_cnt + CNT_ONE;
            overrun_sticky <= 1'b1;
            if (ovr_cnt != '1) ovr_cnt <= ovr_cnt + CNT_ONE;
          end
        end
        COMMIT: begin
          ball_x      <= ball_x_cpu;
          ball_y      <= ball_y_cpu;
          carry_frame <= 1'b0;
          if (frame_edge) frame_cnt <= frame_cnt + CNT_ONE;
          state <= (frame_edge || carry_frame) ? PENDING : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
